// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, product select codes, FSM state
// encoding and default prices used by coin_credit_fsm and credit_timer.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } vend_state_t;

    localparam logic [4:0] COIN_5  = 5'd5;
    localparam logic [4:0] COIN_10 = 5'd10;
    localparam logic [4:0] COIN_20 = 5'd20;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_NEWS  = 2'b01;
    localparam logic [1:0] SEL_CHOC  = 2'b10;
    localparam logic [1:0] SEL_JUICE = 2'b11;

    localparam int DEF_PRICE_NEWS     = 5;
    localparam int DEF_PRICE_CHOC     = 10;
    localparam int DEF_PRICE_JUICE    = 15;
    localparam int DEF_MAX_CREDIT     = 30;
    localparam int DEF_TIMEOUT_CYCLES = 200;

    function automatic logic coin_is_legal(input logic [4:0] value);
        return (value == COIN_5) || (value == COIN_10) || (value == COIN_20);
    endfunction

endpackage

// File: rtl/credit_timer.sv
// Idle-cycle counter for the CREDIT state; expired is high during the
// TIMEOUT_CYCLES-th consecutive active cycle.
module credit_timer
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = active && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !active || expired) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/coin_credit_fsm.sv
// Coin-operated vending credit controller: accepts coins, sells products,
// returns change. Optional idle refund timer is enabled by COIN_TIMEOUT_EN.
module coin_credit_fsm
    import vend_pkg::*;
#(
    parameter int PRICE_NEWS     = DEF_PRICE_NEWS,
    parameter int PRICE_CHOC     = DEF_PRICE_CHOC,
    parameter int PRICE_JUICE    = DEF_PRICE_JUICE,
    parameter int MAX_CREDIT     = DEF_MAX_CREDIT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [4:0] coin,
    input  logic       select_valid,
    input  logic [1:0] select_product,
    input  logic       cancel,
    input  logic       vend_ready,
    output logic       vend_valid,
    output logic [1:0] vend_product,
    output logic [4:0] money,
    output logic [4:0] change,
    output logic       change_valid,
    output logic       coin_reject,
    output logic [4:0] credit
);

    localparam logic [4:0] P_NEWS  = 5'(PRICE_NEWS);
    localparam logic [4:0] P_CHOC  = 5'(PRICE_CHOC);
    localparam logic [4:0] P_JUICE = 5'(PRICE_JUICE);
    localparam logic [5:0] P_MAX   = 6'(MAX_CREDIT);

    vend_state_t state, state_nx;
    logic [4:0]  credit_nx, money_nx, change_nx, sel_price;
    logic [1:0]  product_nx;
    logic        change_valid_nx, coin_reject_nx;
    logic [5:0]  credit_sum;
    logic        coin_ok, sel_ok, timeout_hit;

    // vend_valid/vend_ready: the request is raised the cycle after a purchase
    // is accepted, product and money stay frozen while vend_valid is high, and
    // the transfer happens on the first rising edge where both are high.
    assign vend_valid = (state == VEND);

`ifdef COIN_TIMEOUT_EN
    credit_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_credit_timer (
        .clock   (clock),
        .reset   (reset),
        .active  ((state == CREDIT) && !coin_valid && !select_valid),
        .expired (timeout_hit)
    );
`else
    // Without the timer TIMEOUT_CYCLES has no effect; this is constant zero.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        sel_price = '0;
        case (select_product)
            SEL_NEWS:  sel_price = P_NEWS;
            SEL_CHOC:  sel_price = P_CHOC;
            SEL_JUICE: sel_price = P_JUICE;
            default:   sel_price = '0;
        endcase
        credit_sum = {1'b0, credit} + {1'b0, coin};
        coin_ok    = coin_is_legal(coin) && (credit_sum <= P_MAX);
        sel_ok     = select_valid && (select_product != SEL_NONE) && (credit >= sel_price);
    end

    always_comb begin
        state_nx        = state;
        credit_nx       = credit;
        product_nx      = vend_product;
        money_nx        = money;
        change_nx       = '0;
        change_valid_nx = 1'b0;
        coin_reject_nx  = 1'b0;
        case (state)
            IDLE, CREDIT: begin
                // A coin wins over any select or cancel in the same cycle.
                if (coin_valid) begin
                    if (coin_ok) begin
                        credit_nx = credit_sum[4:0];
                        state_nx  = CREDIT;
                    end else begin
                        coin_reject_nx = 1'b1;
                    end
                end else if (state == CREDIT) begin
                    if (sel_ok) begin
                        state_nx   = VEND;
                        product_nx = select_product;
                        money_nx   = sel_price;
                    end else if (cancel || timeout_hit) begin
                        state_nx = REFUND;
                    end
                end
            end
            VEND: begin
                coin_reject_nx = coin_valid;
                if (vend_ready) begin
                    change_nx       = credit - money;
                    change_valid_nx = 1'b1;
                    credit_nx       = '0;
                    product_nx      = SEL_NONE;
                    money_nx        = '0;
                    state_nx        = IDLE;
                end
            end
            REFUND: begin
                coin_reject_nx  = coin_valid;
                change_nx       = credit;
                change_valid_nx = 1'b1;
                credit_nx       = '0;
                state_nx        = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            credit       <= '0;
            vend_product <= SEL_NONE;
            money        <= '0;
            change       <= '0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            state        <= state_nx;
            credit       <= credit_nx;
            vend_product <= product_nx;
            money        <= money_nx;
            change       <= change_nx;
            change_valid <= change_valid_nx;
            coin_reject  <= coin_reject_nx;
        end
    end

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Bench for coin_credit_fsm: directed vector table, random run against a
// behavioural credit model, and an idle-refund sequence under COIN_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_coin_credit_fsm;

    localparam int MAXC = 30;
    localparam int TMO  = 8;
`ifdef COIN_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    // clock / reset
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [4:0] coin = '0;
    logic       select_valid = 1'b0;
    logic [1:0] select_product = '0;
    logic       cancel = 1'b0;
    logic       vend_ready = 1'b0;
    logic       vend_valid;
    logic [1:0] vend_product;
    logic [4:0] money, change, credit;
    logic       change_valid, coin_reject;

    always #5 clock = ~clock;

    coin_credit_fsm #(
        .PRICE_NEWS(5), .PRICE_CHOC(10), .PRICE_JUICE(15),
        .MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin(coin),
        .select_valid(select_valid), .select_product(select_product),
        .cancel(cancel), .vend_ready(vend_ready), .vend_valid(vend_valid),
        .vend_product(vend_product), .money(money), .change(change),
        .change_valid(change_valid), .coin_reject(coin_reject), .credit(credit)
    );

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver
    task automatic drive(input logic rst, input logic cv, input logic [4:0] c,
                         input logic sv, input logic [1:0] sp, input logic cn,
                         input logic vr);
        reset = rst; coin_valid = cv; coin = c;
        select_valid = sv; select_product = sp; cancel = cn; vend_ready = vr;
    endtask

    // directed vectors
    typedef struct {
        logic rst; logic cv; logic [4:0] coin; logic sv; logic [1:0] sp;
        logic cn; logic vr;
        logic [4:0] e_credit; logic e_vv; logic [1:0] e_prod; logic [4:0] e_money;
        logic e_chv; logic [4:0] e_chg; logic e_rej;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input int rst, cv, c, sv, sp, cn, vr,
                                input int ecr, evv, epr, emo, echv, echg, erej);
        vec_t v;
        v.rst = 1'(rst); v.cv = 1'(cv); v.coin = 5'(c); v.sv = 1'(sv);
        v.sp = 2'(sp); v.cn = 1'(cn); v.vr = 1'(vr);
        v.e_credit = 5'(ecr); v.e_vv = 1'(evv); v.e_prod = 2'(epr);
        v.e_money = 5'(emo); v.e_chv = 1'(echv); v.e_chg = 5'(echg);
        v.e_rej = 1'(erej);
        return v;
    endfunction

    // behavioural model: credit in coins, a pending sale, a pending refund
    int m_credit, m_price, m_prod, m_idle;
    bit m_vend, m_refund, m_chv, m_rej;

    function automatic int price_of(input logic [1:0] sp);
        case (sp)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 15;
            default: return 0;
        endcase
    endfunction

    task automatic model_update();
        int p;
        m_chv = 1'b0;
        m_rej = 1'b0;
        if (reset) begin
            m_credit = 0; m_price = 0; m_prod = 0; m_idle = 0;
            m_vend = 1'b0; m_refund = 1'b0;
        end else if (m_refund) begin
            m_rej = coin_valid;
            m_chv = 1'b1;
            exp_q.push_back(5'(m_credit));
            m_credit = 0; m_refund = 1'b0;
        end else if (m_vend) begin
            m_rej = coin_valid;
            if (vend_ready) begin
                m_chv = 1'b1;
                exp_q.push_back(5'(m_credit - m_price));
                m_credit = 0; m_price = 0; m_prod = 0; m_vend = 1'b0;
            end
        end else if (coin_valid) begin
            m_idle = 0;
            if ((coin == 5 || coin == 10 || coin == 20) && (m_credit + int'(coin) <= MAXC))
                m_credit += int'(coin);
            else
                m_rej = 1'b1;
        end else if (m_credit > 0) begin
            p = price_of(select_product);
            if (select_valid) m_idle = 0;
            else m_idle++;
            if (select_valid && select_product != 2'b00 && m_credit >= p) begin
                m_vend = 1'b1; m_price = p; m_prod = int'(select_product); m_idle = 0;
            end else if (cancel || (TMO_ON && m_idle >= TMO)) begin
                m_refund = 1'b1; m_idle = 0;
            end
        end
    endtask

    // scoreboard step: drive, predict, clock, compare
    task automatic step(input string tag, input logic rst, input logic cv,
                        input logic [4:0] c, input logic sv, input logic [1:0] sp,
                        input logic cn, input logic vr);
        drive(rst, cv, c, sv, sp, cn, vr);
        model_update();
        @(posedge clock);
        #1;
        chk({tag, " credit"}, credit, m_credit);
        chk({tag, " vend_valid"}, vend_valid, m_vend);
        chk({tag, " vend_product"}, vend_product, m_prod);
        chk({tag, " money"}, money, m_price);
        chk({tag, " coin_reject"}, coin_reject, m_rej);
        chk({tag, " change_valid"}, change_valid, m_chv);
        if (change_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL %s change: got strobe %0d expected no strobe", tag, change);
            end else begin
                chk({tag, " change"}, change, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [4:0] rc;

        vecs.push_back(mk(1,0, 0,0,0,0,0,  0,0,0, 0,0, 0,0)); // reset state
        vecs.push_back(mk(0,1,10,0,0,0,0, 10,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1, 5,0,0,0,0, 15,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,0, 0,1,2,0,0, 15,1,2,10,0, 0,0)); // choc
        vecs.push_back(mk(0,0, 0,0,0,0,1,  0,0,0, 0,1, 5,0)); // handshake
        vecs.push_back(mk(0,0, 0,0,0,0,0,  0,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1,10,0,0,0,0, 10,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1,10,0,0,0,0, 20,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1,20,0,0,0,0, 20,0,0, 0,0, 0,1)); // over ceiling
        vecs.push_back(mk(0,0, 0,0,0,0,0, 20,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,0, 0,0,0,1,0, 20,0,0, 0,0, 0,0)); // cancel
        vecs.push_back(mk(0,0, 0,0,0,0,0,  0,0,0, 0,1,20,0));
        vecs.push_back(mk(0,1, 5,0,0,0,0,  5,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,0, 0,1,3,0,0,  5,0,0, 0,0, 0,0)); // juice too dear
        vecs.push_back(mk(0,0, 0,0,0,1,0,  5,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,0, 0,0,0,0,0,  0,0,0, 0,1, 5,0));
        vecs.push_back(mk(0,0, 0,0,0,1,0,  0,0,0, 0,0, 0,0)); // cancel in idle
        vecs.push_back(mk(0,0, 0,0,0,0,0,  0,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1,20,0,0,0,0, 20,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,0, 0,1,1,0,0, 20,1,1, 5,0, 0,0)); // news
        vecs.push_back(mk(0,1, 5,0,0,0,0, 20,1,1, 5,0, 0,1)); // coin in vend
        vecs.push_back(mk(0,0, 0,0,0,0,0, 20,1,1, 5,0, 0,0));
        vecs.push_back(mk(0,0, 0,0,0,1,0, 20,1,1, 5,0, 0,0));
        vecs.push_back(mk(0,0, 0,1,3,0,0, 20,1,1, 5,0, 0,0));
        vecs.push_back(mk(0,0, 0,0,0,0,1,  0,0,0, 0,1,15,0));
        vecs.push_back(mk(0,1,10,1,1,0,0, 10,0,0, 0,0, 0,0)); // coin beats select
        vecs.push_back(mk(0,0, 0,0,0,0,0, 10,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,0, 0,1,1,0,0, 10,1,1, 5,0, 0,0));
        vecs.push_back(mk(1,0, 0,0,0,0,0,  0,0,0, 0,0, 0,0)); // reset in vend
        vecs.push_back(mk(0,0, 0,0,0,0,0,  0,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1, 5,0,0,1,0,  5,0,0, 0,0, 0,0)); // coin beats cancel
        vecs.push_back(mk(0,0, 0,0,0,0,0,  5,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1,20,0,0,0,0, 25,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1, 5,0,0,0,0, 30,0,0, 0,0, 0,0)); // exactly ceiling
        vecs.push_back(mk(0,1, 5,0,0,0,0, 30,0,0, 0,0, 0,1));
        vecs.push_back(mk(0,0, 0,1,3,0,0, 30,1,3,15,0, 0,0));
        vecs.push_back(mk(0,0, 0,0,0,0,1,  0,0,0, 0,1,15,0));
        vecs.push_back(mk(0,1, 7,0,0,0,0,  0,0,0, 0,0, 0,1)); // bad value
        vecs.push_back(mk(0,1, 0,0,0,0,0,  0,0,0, 0,0, 0,1));
        vecs.push_back(mk(0,1,10,0,0,0,0, 10,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,0, 0,0,0,1,0, 10,0,0, 0,0, 0,0));
        vecs.push_back(mk(1,0, 0,0,0,0,0,  0,0,0, 0,0, 0,0)); // reset in refund
        vecs.push_back(mk(0,0, 0,0,0,0,0,  0,0,0, 0,0, 0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].cv, vecs[i].coin, vecs[i].sv,
                  vecs[i].sp, vecs[i].cn, vecs[i].vr);
            @(posedge clock);
            #1;
            chk($sformatf("row%0d credit", i), credit, vecs[i].e_credit);
            chk($sformatf("row%0d vend_valid", i), vend_valid, vecs[i].e_vv);
            chk($sformatf("row%0d vend_product", i), vend_product, vecs[i].e_prod);
            chk($sformatf("row%0d money", i), money, vecs[i].e_money);
            chk($sformatf("row%0d change_valid", i), change_valid, vecs[i].e_chv);
            chk($sformatf("row%0d coin_reject", i), coin_reject, vecs[i].e_rej);
            if (vecs[i].e_chv)
                chk($sformatf("row%0d change", i), change, vecs[i].e_chg);
        end

`ifdef COIN_TIMEOUT_EN
        step("tmo rst", 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("tmo coin", 1'b0, 1'b1, 5'd10, 1'b0, 2'd0, 1'b0, 1'b0);
        n = 0;
        while (!change_valid && n < 20) begin
            n++;
            step("tmo idle", 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        chk("timeout latency", n, TMO + 1);
`endif

        step("rnd rst", 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 3))
                0:       rc = 5'd5;
                1:       rc = 5'd10;
                2:       rc = 5'd20;
                default: rc = 5'($urandom_range(0, 31));
            endcase
            step("rnd", 1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 9) < 3), rc,
                 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end

        chk("leftover expected change", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_credit_fsm.md
COIN_CREDIT_FSM -- requirements
Module: coin_credit_fsm

Interface
REQ-001 SHALL have parameter PRICE_NEWS, default 5, newspaper price.
REQ-002 SHALL have parameter PRICE_CHOC, default 10, candy price.
REQ-003 SHALL have parameter PRICE_JUICE, default 15, juice price.
REQ-004 SHALL have parameter MAX_CREDIT, default 30, credit ceiling.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 200, idle-refund delay; used only under COIN_TIMEOUT_EN.
REQ-006 SHALL have port: clock  in  1  rising-edge clock.
REQ-007 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port: coin_valid  in  1  coin present this cycle.
REQ-009 SHALL have port: coin  in  5  coin value: 5, 10 or 20.
REQ-010 SHALL have port: select_valid  in  1  product request this cycle.
REQ-011 SHALL have port: select_product  in  2  01 news, 10 choc, 11 juice, 00 none.
REQ-012 SHALL have port: cancel  in  1  refund request.
REQ-013 SHALL have port: vend_ready  in  1  downstream vending stage accepts.
REQ-014 SHALL have port: vend_valid  out  1  vend request to downstream stage.
REQ-015 SHALL have port: vend_product  out  2  product code sent downstream.
REQ-016 SHALL have port: money  out  5  price paid for vend_product.
REQ-017 SHALL have port: change  out  5  amount returned.
REQ-018 SHALL have port: change_valid  out  1  one-cycle strobe qualifying change.
REQ-019 SHALL have port: coin_reject  out  1  one-cycle strobe, coin returned.
REQ-020 SHALL have port: credit  out  5  current accumulated credit.

Function
REQ-021 SHALL implement states IDLE, CREDIT, VEND, REFUND.
REQ-022 SHALL, in IDLE/CREDIT, add an accepted coin to credit the cycle after coin_valid and move to CREDIT.
REQ-023 SHALL reject a coin (coin_reject high next cycle, credit unchanged) if value is not 5/10/20 or credit+coin exceeds MAX_CREDIT; sum computed at 6 bits.
REQ-024 SHALL, in CREDIT with select_valid and credit >= price, latch product, go to VEND, and assert vend_valid the next cycle.
REQ-025 SHALL ignore select_valid with select_product 00 or credit < price; state and credit unchanged.
REQ-026 SHALL hold vend_valid, vend_product, money (= price) stable in VEND until vend_valid && vend_ready.
REQ-027 SHALL, on the handshake cycle, drive change = credit - price with change_valid for one cycle the next cycle, zero credit, and return to IDLE.
REQ-028 SHALL, on cancel in CREDIT, go to REFUND: change = credit, change_valid one cycle, credit 0, then IDLE.
REQ-029 SHALL give coin priority when coin_valid and select_valid/cancel coincide; the other request is dropped.
REQ-030 SHALL reject coins and ignore select/cancel while in VEND or REFUND.
REQ-031 SHALL ignore cancel in IDLE (no change_valid pulse).

Reset
REQ-032 SHALL, on reset, force IDLE, credit 0, vend_valid 0, vend_product 00, money 0, change 0, change_valid 0, coin_reject 0.
REQ-033 SHALL, on reset during VEND or REFUND, drop vend_valid next cycle and discard credit without a change_valid strobe.

Configuration
REQ-034 SHALL, with COIN_TIMEOUT_EN defined, count cycles in CREDIT without coin_valid/select_valid and enter REFUND when the count reaches TIMEOUT_CYCLES; counter clears on any such input.
REQ-035 SHALL, without COIN_TIMEOUT_EN, hold credit in CREDIT indefinitely with no timer logic.

Structure
REQ-036 SHALL take coin constants, select codes, state encoding and default prices from shared package vend_pkg.
REQ-037 SHALL place the timeout counter in sub-module credit_timer, instantiated only under COIN_TIMEOUT_EN.

Verification
REQ-038 SHALL cover: coins 10,5 then select 10 -> credit 15, vend_valid with money 10, after vend_ready change 5 strobe.
REQ-039 SHALL cover: credit 20, coin 20 -> coin_reject one cycle, credit stays 20.
REQ-040 SHALL cover: credit 5, select juice -> ignored; cancel -> change 5 strobe, credit 0.
REQ-041 SHALL cover: VEND with vend_ready low 4 cycles, coin 5 offered -> outputs stable, coin rejected, then handshake completes.
REQ-042 SHALL cover: coin 10 and select news same cycle -> credit 10, no vend; reset during VEND -> vend_valid 0, no change strobe.
REQ-043 SHALL cover with COIN_TIMEOUT_EN, TIMEOUT_CYCLES 8: credit 10, 8 idle cycles -> change 10 strobe.
